// File: rtl/am_search_engine.sv
// ---------------------------------------------------------------------------
// am_search_engine
//
// Associative-memory search for the sparse HDC accelerator. A start pulse in
// IDLE latches the query hypervector, scoring mode, class count and AM base
// address. The engine then issues one AM read per cycle (class k lives at
// base + k*ADDR_STRIDE, wrapping modulo 2^AM_ADDR_WIDTH). It scores each
// returned class vector by popcount and tracks the best class, the best score
// and the runner-up score.
//
// Handshake: start_i is a single-cycle request that is only accepted while
// the FSM is in IDLE. busy_o covers ISSUE and DRAIN. done_o pulses for
// exactly one cycle when results are final. Results and err_o then hold
// until the next accepted start.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             search request
//   query_hv_i          query hypervector (sampled on accepted start)
//   mode_i              0 = AND overlap, 1 = XNOR match
//   num_classes_i       number of classes (1..MAX_CLASSES is valid)
//   am_addr_base_i      AM address of class 0
//   am_addr_o/am_ren_o  AM read request
//   am_rdata_i          AM read data, RD_LATENCY cycles after am_ren_o
//   busy_o, done_o      status
//   err_o               invalid class count (valid with done_o, held)
//   best_class_o        index of best class (ties keep lowest index)
//   best_score_o        best score
//   runner_score_o      second-best score (0 when only one class)
// ---------------------------------------------------------------------------
module am_search_engine #(
  parameter int HV_LENGTH     = 8192,
  parameter int AM_ADDR_WIDTH = 13,
  parameter int MAX_CLASSES   = 32,
  parameter int ADDR_STRIDE   = 256,
  parameter int RD_LATENCY    = 1,
  parameter int CLS_W         = $clog2(MAX_CLASSES),
  parameter int CNT_W         = $clog2(HV_LENGTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [HV_LENGTH-1:0]     query_hv_i,
  input  logic                     mode_i,
  input  logic [CLS_W:0]           num_classes_i,
  input  logic [AM_ADDR_WIDTH-1:0] am_addr_base_i,
  output logic [AM_ADDR_WIDTH-1:0] am_addr_o,
  output logic                     am_ren_o,
  input  logic [HV_LENGTH-1:0]     am_rdata_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [CLS_W-1:0]         best_class_o,
  output logic [CNT_W-1:0]         best_score_o,
  output logic [CNT_W-1:0]         runner_score_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [AM_ADDR_WIDTH-1:0] STRIDE = AM_ADDR_WIDTH'(ADDR_STRIDE);
  localparam logic [CLS_W:0]           MAX_N  = (CLS_W + 1)'(MAX_CLASSES);

  state_e state_q, state_d;

  // Latched search context
  logic [HV_LENGTH-1:0]     query_q;
  logic                     mode_q;
  logic [CLS_W:0]           num_q;
  logic [AM_ADDR_WIDTH-1:0] addr_q;
  logic [CLS_W-1:0]         issue_cls_q;

  // Tag pipeline aligned with the AM read latency
  logic                     vld_pipe_q [RD_LATENCY];
  logic [CLS_W-1:0]         cls_pipe_q [RD_LATENCY];

  // Registered score stage
  logic                     score_vld_q;
  logic [CLS_W-1:0]         score_cls_q;
  logic [CNT_W-1:0]         score_q;

  // Results
  logic [CLS_W-1:0]         best_cls_q;
  logic [CNT_W-1:0]         best_q;
  logic [CNT_W-1:0]         runner_q;
  logic                     err_q;

  logic start_acc;
  logic start_ok;
  logic last_issue;
  logic last_score;
  logic [HV_LENGTH-1:0] match_vec;

  function automatic logic [CNT_W-1:0] popcount(input logic [HV_LENGTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < HV_LENGTH; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  assign start_acc  = (state_q == S_IDLE) && start_i;
  assign start_ok   = (num_classes_i != '0) && (num_classes_i <= MAX_N);
  assign last_issue = ({1'b0, issue_cls_q} == (num_q - 1'b1));
  assign last_score = ({1'b0, score_cls_q} == (num_q - 1'b1));
  assign match_vec  = mode_q ? ~(am_rdata_i ^ query_q) : (am_rdata_i & query_q);

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = start_ok ? S_ISSUE : S_DONE;
      S_ISSUE: if (last_issue) state_d = S_DRAIN;
      S_DRAIN: if (score_vld_q && last_score) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign am_ren_o = (state_q == S_ISSUE);
  assign am_addr_o = addr_q;
  assign busy_o   = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done_o   = (state_q == S_DONE);

  // ---------------- Context and read issue ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      query_q     <= '0;
      mode_q      <= 1'b0;
      num_q       <= '0;
      addr_q      <= '0;
      issue_cls_q <= '0;
    end else if (start_acc) begin
      query_q     <= query_hv_i;
      mode_q      <= mode_i;
      num_q       <= num_classes_i;
      addr_q      <= am_addr_base_i;
      issue_cls_q <= '0;
    end else if (state_q == S_ISSUE) begin
      // Address add truncates naturally, giving the modulo wrap.
      addr_q      <= addr_q + STRIDE;
      issue_cls_q <= issue_cls_q + 1'b1;
    end
  end

  // ---------------- Tag pipeline and score stage ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_pipe_q[i] <= 1'b0;
        cls_pipe_q[i] <= '0;
      end
      score_vld_q <= 1'b0;
      score_cls_q <= '0;
      score_q     <= '0;
    end else begin
      vld_pipe_q[0] <= am_ren_o;
      cls_pipe_q[0] <= issue_cls_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        cls_pipe_q[i] <= cls_pipe_q[i-1];
      end
      score_vld_q <= vld_pipe_q[RD_LATENCY-1];
      score_cls_q <= cls_pipe_q[RD_LATENCY-1];
      // Read data is only meaningful when the aligned tag is valid.
      if (vld_pipe_q[RD_LATENCY-1]) begin
        score_q <= popcount(match_vec);
      end
    end
  end

  // ---------------- Compare / results ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      best_cls_q <= '0;
      best_q     <= '0;
      runner_q   <= '0;
      err_q      <= 1'b0;
    end else if (start_acc) begin
      best_cls_q <= '0;
      best_q     <= '0;
      runner_q   <= '0;
      err_q      <= ~start_ok;
    end else if (score_vld_q) begin
      if (score_cls_q == '0) begin
        best_cls_q <= '0;
        best_q     <= score_q;
        runner_q   <= '0;
      end else if (score_q > best_q) begin
        // Strict compare: equal scores keep the earlier (lower) index.
        runner_q   <= best_q;
        best_q     <= score_q;
        best_cls_q <= score_cls_q;
      end else if (score_q > runner_q) begin
        runner_q   <= score_q;
      end
    end
  end

  assign err_o          = err_q;
  assign best_class_o   = best_cls_q;
  assign best_score_o   = best_q;
  assign runner_score_o = runner_q;

endmodule

// File: tb/tb_am_search_engine.sv
// ---------------------------------------------------------------------------
// tb_am_search_engine
//
// Two engine instances share all request inputs: one with a 1-cycle AM read
// latency and one with a 3-cycle latency. Each has its own AM model (same
// memory contents, different read delay). Scores are predicted from the
// memory contents with $countones, and best/runner are found by a max
// search over the score list.
// ---------------------------------------------------------------------------
module tb_am_search_engine;

  localparam int HV  = 16;
  localparam int AW  = 13;
  localparam int MAXC = 32;
  localparam int CW  = 5;
  localparam int NW  = 5;
  localparam int LAT [2] = '{1, 3};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- shared request inputs ----------------
  logic          start;
  logic [HV-1:0] query;
  logic          mode;
  logic [CW:0]   num;
  logic [AW-1:0] base;

  // ---------------- per-instance outputs ----------------
  logic [AW-1:0] am_addr [2];
  logic          am_ren  [2];
  logic [HV-1:0] rdata   [2];
  logic          busy    [2];
  logic          done    [2];
  logic          err     [2];
  logic [CW-1:0] bcls    [2];
  logic [NW-1:0] bsc     [2];
  logic [NW-1:0] rsc     [2];

  // ---------------- AM models ----------------
  logic [HV-1:0] am_mem [1 << AW];
  logic [HV-1:0] d1;
  logic [HV-1:0] d3 [3];

  // Non-read cycles return random garbage that the engine must ignore.
  always @(posedge clk) begin
    d1 <= am_ren[0] ? am_mem[am_addr[0]] : HV'($urandom);
  end
  always @(posedge clk) begin
    d3[0] <= am_ren[1] ? am_mem[am_addr[1]] : HV'($urandom);
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end
  assign rdata[0] = d1;
  assign rdata[1] = d3[2];

  am_search_engine #(
    .HV_LENGTH(HV), .AM_ADDR_WIDTH(AW), .MAX_CLASSES(MAXC),
    .ADDR_STRIDE(256), .RD_LATENCY(1)
  ) dut_l1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .query_hv_i(query),
    .mode_i(mode), .num_classes_i(num), .am_addr_base_i(base),
    .am_addr_o(am_addr[0]), .am_ren_o(am_ren[0]), .am_rdata_i(rdata[0]),
    .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0]),
    .best_class_o(bcls[0]), .best_score_o(bsc[0]), .runner_score_o(rsc[0])
  );

  am_search_engine #(
    .HV_LENGTH(HV), .AM_ADDR_WIDTH(AW), .MAX_CLASSES(MAXC),
    .ADDR_STRIDE(256), .RD_LATENCY(3)
  ) dut_l3 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .query_hv_i(query),
    .mode_i(mode), .num_classes_i(num), .am_addr_base_i(base),
    .am_addr_o(am_addr[1]), .am_ren_o(am_ren[1]), .am_rdata_i(rdata[1]),
    .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1]),
    .best_class_o(bcls[1]), .best_score_o(bsc[1]), .runner_score_o(rsc[1])
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] class_addr(input logic [AW-1:0] b, input int k);
    return AW'(int'(b) + k * 256);
  endfunction

  task automatic check_outputs_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_ren"},    32'(am_ren[i]),  0);
      check({tag, "_addr"},   32'(am_addr[i]), 0);
      check({tag, "_busy"},   32'(busy[i]),    0);
      check({tag, "_done"},   32'(done[i]),    0);
      check({tag, "_err"},    32'(err[i]),     0);
      check({tag, "_bcls"},   32'(bcls[i]),    0);
      check({tag, "_best"},   32'(bsc[i]),     0);
      check({tag, "_runner"}, 32'(rsc[i]),     0);
    end
  endtask

  // Runs one search request on both instances and checks the full
  // transaction: read addresses and count, busy window, done timing,
  // results and their holding after done. extra_at >= 2 re-pulses start
  // with different arguments at that cycle, which must be ignored.
  task automatic run_search(input string tag, input int n, input logic [AW-1:0] b,
                            input logic m, input logic [HV-1:0] q, input int extra_at);
    logic [NW-1:0] exp_q [$];
    int  is_err;
    int  exp_cls, exp_best, exp_run;
    int  done_exp [2];
    int  nreads [2];
    int  ndone [2];
    int  budget;
    logic [HV-1:0] row;

    is_err = (n == 0 || n > MAXC);
    exp_cls = 0; exp_best = 0; exp_run = 0;
    if (!is_err) begin
      for (int k = 0; k < n; k++) begin
        row = am_mem[class_addr(b, k)];
        exp_q.push_back(NW'(m ? $countones(~(row ^ q)) : $countones(row & q)));
      end
      for (int k = 0; k < n; k++)
        if (int'(exp_q[k]) > exp_best) begin exp_best = exp_q[k]; exp_cls = k; end
      if (n > 1) begin
        exp_best = exp_q[0]; exp_cls = 0;
        for (int k = 1; k < n; k++)
          if (int'(exp_q[k]) > exp_best) begin exp_best = exp_q[k]; exp_cls = k; end
        for (int k = 0; k < n; k++)
          if (k != exp_cls && int'(exp_q[k]) > exp_run) exp_run = exp_q[k];
      end
    end
    for (int i = 0; i < 2; i++) begin
      done_exp[i] = is_err ? 1 : n + LAT[i] + 2;
      nreads[i] = 0;
      ndone[i]  = 0;
    end
    budget = is_err ? 5 : n + 8;

    @(negedge clk);
    start = 1'b1; query = q; mode = m; num = (CW+1)'(n); base = b;
    @(posedge clk);   // cycle-0 edge: start accepted here

    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (am_ren[i]) begin
          check({tag, "_read_cycle_in_window"}, 32'(c >= 1 && c <= n && !is_err), 1);
          check({tag, "_addr"}, 32'(am_addr[i]), 32'(class_addr(b, c - 1)));
          nreads[i]++;
        end
        check({tag, "_busy"}, 32'(busy[i]), 32'(!is_err && c < done_exp[i]));
        if (done[i]) begin
          ndone[i]++;
          check({tag, "_done_cycle"}, c, done_exp[i]);
          check({tag, "_err"},    32'(err[i]),  32'(is_err));
          check({tag, "_bcls"},   32'(bcls[i]), exp_cls);
          check({tag, "_best"},   32'(bsc[i]),  exp_best);
          check({tag, "_runner"}, 32'(rsc[i]),  exp_run);
        end
      end
      // Inputs change right after the request so latching is exercised.
      start = 1'b0;
      query = HV'($urandom); mode = 1'($urandom); base = AW'($urandom);
      num = (CW+1)'($urandom_range(1, MAXC));
      if (extra_at >= 2 && c == extra_at) start = 1'b1;
    end

    for (int i = 0; i < 2; i++) begin
      check({tag, "_read_count"}, nreads[i], is_err ? 0 : n);
      check({tag, "_done_count"}, ndone[i], 1);
      check({tag, "_hold_err"},    32'(err[i]),  32'(is_err));
      check({tag, "_hold_bcls"},   32'(bcls[i]), exp_cls);
      check({tag, "_hold_best"},   32'(bsc[i]),  exp_best);
      check({tag, "_hold_runner"}, 32'(rsc[i]),  exp_run);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int rn;
    logic [AW-1:0] rb;
    int ex;

    rst = 1'b1; start = 1'b0; query = '0; mode = 1'b0; num = '0; base = '0;
    for (int a = 0; a < (1 << AW); a++) am_mem[a] = HV'($urandom);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // AND overlap, three classes: scores 8,8,12
    am_mem[13'h100] = 16'h00FF; am_mem[13'h200] = 16'h0F0F; am_mem[13'h300] = 16'hFFFF;
    run_search("and3", 3, 13'h100, 1'b0, 16'h0FFF, 0);

    // Tie keeps lowest index
    am_mem[13'h400] = 16'hF000; am_mem[13'h500] = 16'h0F00;
    run_search("tie", 2, 13'h400, 1'b0, 16'hFF00, 0);

    // XNOR match: scores 0 and 15
    am_mem[13'h600] = 16'hFFFF; am_mem[13'h700] = 16'h0001;
    run_search("xnor", 2, 13'h600, 1'b1, 16'h0000, 0);

    // Address wrap 0x1F00 -> 0x0000
    run_search("wrap", 2, 13'h1F00, 1'b0, 16'hA5C3, 0);

    // Invalid counts
    run_search("err_zero", 0, 13'h100, 1'b0, 16'h0FFF, 0);
    run_search("err_over", MAXC + 1, 13'h100, 1'b0, 16'h0FFF, 0);

    // Start re-pulsed during ISSUE is ignored
    run_search("extra_start", 3, 13'h100, 1'b0, 16'h0FFF, 2);

    // Boundary counts
    run_search("n_one", 1, 13'h0123, 1'b1, 16'h3C3C, 0);
    run_search("n_max", MAXC, 13'h0777, 1'b0, 16'hFFFF, 5);

    // Reset mid-ISSUE: all outputs cleared, no done, then a fresh search
    @(negedge clk);
    start = 1'b1; query = 16'h0FFF; mode = 1'b0; num = 6'd5; base = 13'h0040;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("mid_reset");
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check("post_reset_no_done", 32'(done[i]), 0);
        check("post_reset_no_ren",  32'(am_ren[i]), 0);
      end
    end
    run_search("after_reset", 3, 13'h100, 1'b0, 16'h0FFF, 0);

    // Randomized searches
    for (int t = 0; t < 20; t++) begin
      rn = $urandom_range(1, MAXC);
      if (t % 7 == 6) rn = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAXC + 1, 63);
      rb = AW'($urandom);
      ex = ($urandom_range(0, 2) == 0 && rn >= 3 && rn <= MAXC) ? 2 : 0;
      run_search("rand", rn, rb, 1'($urandom), HV'($urandom), ex);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/am_search_engine.md
Name:
am_search_engine

Overview:
Parametrised associative-memory search engine for the sparse HDC accelerator. On a start pulse it latches the encoded query hypervector and streams a configurable number of class vectors out of the AM, issuing one read per cycle. It scores each class by AND-overlap or XNOR-match popcount and reports the best class, the best score and the runner-up score. It sits between the encoder output and the host result interface.

Parameters:
HV_LENGTH, 8192, hypervector width in bits
AM_ADDR_WIDTH, 13, AM address width
MAX_CLASSES, 32, maximum number of classes searched
ADDR_STRIDE, 256, address increment between consecutive class vectors
RD_LATENCY, 1, AM read latency in cycles (am_ren_o to am_rdata_i valid), range 1..4
CLS_W, $clog2(MAX_CLASSES), class index width (derived)
CNT_W, $clog2(HV_LENGTH+1), score width (derived)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
start_i  in  1  search request; accepted only in IDLE
query_hv_i  in  HV_LENGTH  query hypervector; sampled on accepted start
mode_i  in  1  0 = AND overlap, 1 = XNOR match; sampled on accepted start
num_classes_i  in  CLS_W+1  number of classes to search; sampled on accepted start
am_addr_base_i  in  AM_ADDR_WIDTH  address of class 0; sampled on accepted start
am_addr_o  out  AM_ADDR_WIDTH  AM read address
am_ren_o  out  1  AM read enable
am_rdata_i  in  HV_LENGTH  AM read data
busy_o  out  1  high from the cycle after the accepted start until done_o
done_o  out  1  one-cycle completion pulse
err_o  out  1  invalid num_classes; valid with done_o, held
best_class_o  out  CLS_W  index of the best-scoring class
best_score_o  out  CNT_W  best score
runner_score_o  out  CNT_W  second-best score (0 if only one class)

Behaviour:
- Reset: FSM to IDLE. am_ren_o, am_addr_o, busy_o, done_o, err_o, best_class_o, best_score_o, runner_score_o and all pipeline valid bits are 0. Reset mid-search aborts the search; no done_o is produced.
- FSM states are IDLE, ISSUE, DRAIN, DONE.
- IDLE -> ISSUE on start_i with 1 <= num_classes_i <= MAX_CLASSES. Query, mode, count and base are latched. Result outputs are cleared to 0 at the same edge.
- IDLE -> DONE on start_i with num_classes_i == 0 or > MAX_CLASSES. No AM reads are issued. err_o = 1 and results = 0.
- ISSUE: am_ren_o = 1 for exactly N consecutive cycles (N = latched count). am_addr_o = base + k*ADDR_STRIDE for k = 0..N-1, truncated to AM_ADDR_WIDTH, so addresses wrap modulo 2^AM_ADDR_WIDTH. Move to DRAIN after read N-1 is issued.
- Tag pipeline: the class index and a valid bit are delayed RD_LATENCY cycles to align with am_rdata_i.
- Scoring: score = popcount(am_rdata_i & q) in AND mode, or popcount(~(am_rdata_i ^ q)) in XNOR mode. The score is registered, giving one stage after read data.
- Compare, one score per cycle:
  - The first score (k = 0) loads best_score = score, best_class = 0, runner = 0.
  - For later scores: if score > best, then runner <= best, best <= score, best_class <= k.
  - Else if score > runner, then runner <= score.
  - Ties keep the lower index.
- DRAIN -> DONE after the compare for k = N-1 completes.
- DONE: done_o = 1 for one cycle, then return to IDLE.
- Latency: with the start accepted at cycle 0, reads occur at cycles 1..N and done_o at cycle N+RD_LATENCY+2. For the error path, done_o is at cycle 1.
- Result holding: results and err_o hold from done_o until the next accepted start.
- start_i while busy_o or done_o is high is ignored and has no effect on the search in progress.
- busy_o is high in ISSUE and DRAIN; it is low in IDLE and DONE.
- am_rdata_i is ignored when the aligned valid bit is 0.

Test Plan:
- HV_LENGTH=16, AND mode, N=3, base=0x100, class rows 0x00FF/0x0F0F/0xFFFF, query 0x0FFF -> addresses 0x100,0x200,0x300; scores 8,8,12; best_class=2, best=12, runner=8; done_o exactly at cycle 3+RD_LATENCY+2.
- Tie: rows 0xF000/0x0F00, query 0xFF00, N=2 -> both score 4; best_class=0, best=4, runner=4.
- XNOR mode: query 0x0000, rows 0xFFFF/0x0001 -> scores 0 and 15; best_class=1, best=15, runner=0.
- Wrap: AM_ADDR_WIDTH=13, base=0x1F00, N=2 -> addresses 0x1F00 then 0x0000.
- num_classes_i=0, and separately MAX_CLASSES+1 -> no am_ren_o; done_o at cycle 1; err_o=1; results 0.
- start_i pulsed during ISSUE, and rst_i asserted mid-ISSUE: the extra start is ignored with results unchanged. Reset gives all outputs 0 at the next edge, no done_o, and a fresh search afterwards completes correctly.
- RD_LATENCY=3 regression of the first scenario -> same results, done_o at cycle 8.
